// File: rtl/sram_block_mentor_pkg.sv
// Shared definitions for the sram_1Mx8 Wishbone block mentor.
// Holds the cycle-tag encodings driven on TGC_O, the FSM state type, and a helper that maps the
// transfer direction onto its cycle tag.
package sram_block_mentor_pkg;

  // Cycle tags presented on TGC_O. The read tag is all-zero so an idle or reset bus has WE_O and
  // TGC_O agreeing.
  localparam logic [1:0] SrCycSrd  = 2'b00;
  localparam logic [1:0] SrCycSwrt = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StStrobe,
    StGap,
    StFinish
  } state_e;

  function automatic logic [1:0] cyc_tag(input logic we);
    return we ? SrCycSwrt : SrCycSrd;
  endfunction

endpackage

// File: rtl/sram_block_mentor.sv
// Wishbone mentor for sram_1Mx8: turns one request (start address, byte count, direction) into a
// block transfer of single-byte beats inside one CYC_O assertion.
// Ports:
//   CLK_I, RST_I                  clock, asynchronous active-high reset
//   i_req/i_we/i_addr/i_len       request, sampled only when idle
//   o_busy/o_done/o_error         transfer status; o_error qualifies the o_done pulse
//   i_wdata/i_wvalid/o_wready     write-byte source handshake
//   o_rdata/o_rvalid              read-byte sink, no backpressure
//   CYC_O..TGD_O, DAT_I..RTY_I    Wishbone mentor interface to sram_1Mx8
module sram_block_mentor
  import sram_block_mentor_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned CTAG_WIDTH = 2,
  parameter int unsigned ATAG_WIDTH = 2,
  parameter int unsigned DTAG_WIDTH = 2,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [LEN_WIDTH-1:0]  i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rvalid,
  output logic                  CYC_O,
  output logic                  STB_O,
  output logic                  WE_O,
  output logic                  LOCK_O,
  output logic                  SEL_O,
  output logic [ADDR_WIDTH-1:0] ADR_O,
  output logic [DATA_WIDTH-1:0] DAT_O,
  output logic [CTAG_WIDTH-1:0] TGC_O,
  output logic [ATAG_WIDTH-1:0] TGA_O,
  output logic [DTAG_WIDTH-1:0] TGD_O,
  input  logic [DATA_WIDTH-1:0] DAT_I,
  input  logic                  ACK_I,
  input  logic                  ERR_I,
  input  logic                  RTY_I
);

  localparam int unsigned RetryW = $clog2(MAX_RETRY + 2);
  localparam int unsigned WdogW  = $clog2(TIMEOUT + 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);
  localparam logic [WdogW-1:0]  WdogMax  = WdogW'(TIMEOUT - 1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic                  we_q;
  logic                  cyc_q;
  logic                  stb_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;
  logic                  rvalid_q;
  logic                  reissue_q;
  logic [DATA_WIDTH-1:0] wdat_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [RetryW-1:0]     retry_q;
  logic [WdogW-1:0]      wdog_q;

  logic strobe_abort;
  logic gap_done;

  // Abort conditions seen while strobing. ERR_I wins over everything; ACK_I wins over RTY_I.
  always_comb begin
    strobe_abort = 1'b0;
    if (state_q == StStrobe) begin
      if (ERR_I) begin
        strobe_abort = 1'b1;
      end else if (!ACK_I && RTY_I) begin
        // This RTY_I would push the per-beat count past MAX_RETRY.
        strobe_abort = (retry_q == RetryMax);
      end else if (!ACK_I) begin
        strobe_abort = (wdog_q == WdogMax);
      end
    end
  end

  assign gap_done = (state_q == StGap) && (rem_q == '0);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      rem_q     <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      reissue_q <= 1'b0;
      wdat_q    <= '0;
      rdata_q   <= '0;
      retry_q   <= '0;
      wdog_q    <= '0;
    end else begin
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      rvalid_q <= 1'b0;
      if (strobe_abort || gap_done) begin
        state_q <= StFinish;
        cyc_q   <= 1'b0;
        stb_q   <= 1'b0;
        we_q    <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        error_q <= strobe_abort;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (i_req) begin
              if (i_len == '0) begin
                // Empty request: report an error without touching the bus.
                done_q  <= 1'b1;
                error_q <= 1'b1;
              end else begin
                addr_q    <= i_addr;
                rem_q     <= i_len;
                we_q      <= i_we;
                busy_q    <= 1'b1;
                cyc_q     <= 1'b1;
                retry_q   <= '0;
                wdog_q    <= '0;
                reissue_q <= 1'b0;
                if (i_we) begin
                  state_q <= StFetch;
                end else begin
                  stb_q   <= 1'b1;
                  state_q <= StStrobe;
                end
              end
            end
          end
          StFetch: begin
            if (i_wvalid) begin
              wdat_q  <= i_wdata;
              stb_q   <= 1'b1;
              wdog_q  <= '0;
              state_q <= StStrobe;
            end
          end
          StStrobe: begin
            if (ACK_I) begin
              stb_q <= 1'b0;
              if (!we_q) begin
                rdata_q  <= DAT_I;
                rvalid_q <= 1'b1;
              end
              rem_q     <= rem_q - LEN_WIDTH'(1);
              addr_q    <= addr_q + ADDR_WIDTH'(1);
              retry_q   <= '0;
              reissue_q <= 1'b0;
              state_q   <= StGap;
            end else if (RTY_I) begin
              // Same beat goes out again after the gap; write data is kept.
              stb_q     <= 1'b0;
              retry_q   <= retry_q + RetryW'(1);
              reissue_q <= 1'b1;
              state_q   <= StGap;
            end else begin
              wdog_q <= wdog_q + WdogW'(1);
            end
          end
          StGap: begin
            if (we_q && !reissue_q) begin
              state_q <= StFetch;
            end else begin
              stb_q   <= 1'b1;
              wdog_q  <= '0;
              state_q <= StStrobe;
            end
          end
          StFinish: begin
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_error  = error_q;
  assign o_wready = (state_q == StFetch) && i_wvalid;
  assign o_rdata  = rdata_q;
  assign o_rvalid = rvalid_q;

  assign CYC_O  = cyc_q;
  assign STB_O  = stb_q;
  assign WE_O   = we_q;
  assign LOCK_O = 1'b0;
  assign SEL_O  = 1'b1;
  assign ADR_O  = addr_q;
  assign DAT_O  = wdat_q;
  assign TGC_O  = CTAG_WIDTH'(cyc_tag(we_q));
  assign TGA_O  = '0;
  assign TGD_O  = '0;

endmodule

// File: tb/tb_sram_block_mentor.sv
module tb_sram_block_mentor;
  import sram_block_mentor_pkg::*;

  localparam int FNone  = 0;
  localparam int FErr   = 1;
  localparam int FNoAck = 2;
  localparam int FRty4  = 3;
  localparam int FRty2  = 4;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic        i_req = 1'b0;
  logic        i_we = 1'b0;
  logic [19:0] i_addr = '0;
  logic [7:0]  i_len = '0;
  logic        o_busy, o_done, o_error;
  logic [7:0]  i_wdata = '0;
  logic        i_wvalid = 1'b0;
  logic        o_wready;
  logic [7:0]  o_rdata;
  logic        o_rvalid;
  logic        CYC_O, STB_O, WE_O, LOCK_O, SEL_O;
  logic [19:0] ADR_O;
  logic [7:0]  DAT_O;
  logic [1:0]  TGC_O, TGA_O, TGD_O;
  logic [7:0]  DAT_I = '0;
  logic        ACK_I = 1'b0, ERR_I = 1'b0, RTY_I = 1'b0;

  always #5 CLK_I = ~CLK_I;

  sram_block_mentor dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_len(i_len),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .i_wdata(i_wdata),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .o_rdata(o_rdata), .o_rvalid(o_rvalid),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .LOCK_O(LOCK_O), .SEL_O(SEL_O),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .TGC_O(TGC_O), .TGA_O(TGA_O), .TGD_O(TGD_O),
    .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I)
  );

  typedef struct {
    logic [19:0] addr;
    logic        we;
    logic [7:0]  data;
  } beat_t;

  // Scoreboard queues and reference memory.
  beat_t       exp_beats[$];
  logic [7:0]  exp_rd[$];
  logic        exp_done[$];
  logic [7:0]  ref_mem[int];
  logic [7:0]  slv_mem[int];
  logic [7:0]  wq[$];
  logic [7:0]  ovr[$];

  int n_cmp = 0;
  int n_fail = 0;
  int done_count = 0;
  int fetched = 0;
  int cyc_rises = 0;
  int stb_run = 0;
  int last_run = 0;
  int flt_mode = FNone;
  int flt_beat = 0;
  int lat_max = 0;
  int lat = 0;
  int wait_cnt = 0;
  int slv_beat = 1;
  int rty_cnt = 0;
  int wv_stall = 0;
  logic prev_cyc = 1'b0;
  logic took = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Wishbone slave: behavioural byte memory with per-beat latency and fault injection.
  // Every ACK it gives is checked against the next expected beat.
  initial begin
    beat_t eb;
    forever begin
      @(negedge CLK_I);
      ACK_I = 1'b0;
      ERR_I = 1'b0;
      RTY_I = 1'b0;
      DAT_I = 8'($urandom);
      if (CYC_O && !prev_cyc) cyc_rises++;
      prev_cyc = CYC_O;
      if (!CYC_O) begin
        slv_beat = 1;
        rty_cnt  = 0;
        wait_cnt = 0;
      end
      if (CYC_O && STB_O) begin
        stb_run++;
        if (wait_cnt < lat) begin
          wait_cnt++;
        end else begin
          wait_cnt = 0;
          lat = $urandom_range(0, lat_max);
          if (flt_mode == FErr && slv_beat == flt_beat) begin
            ERR_I = 1'b1;
            ACK_I = 1'b1;
          end else if (flt_mode == FNoAck && slv_beat == flt_beat) begin
            ACK_I = 1'b0;
          end else if (slv_beat == flt_beat &&
                       (flt_mode == FRty4 || (flt_mode == FRty2 && rty_cnt < 2))) begin
            RTY_I = 1'b1;
            rty_cnt++;
          end else begin
            ACK_I = 1'b1;
            if (exp_beats.size() == 0) begin
              fail("extra_beat", 32'(ADR_O), 32'hFFFFFFFF);
            end else begin
              eb = exp_beats.pop_front();
              check("beat_addr", 32'(ADR_O), 32'(eb.addr));
              check("beat_we", 32'(WE_O), 32'(eb.we));
              check("beat_tgc", 32'(TGC_O), 32'(eb.we ? SrCycSwrt : SrCycSrd));
              if (eb.we) check("beat_wdata", 32'(DAT_O), 32'(eb.data));
              check("fixed_outs", 32'({SEL_O, LOCK_O, TGA_O, TGD_O}), 32'h20);
            end
            if (WE_O) slv_mem[int'(ADR_O)] = DAT_O;
            else DAT_I = slv_mem.exists(int'(ADR_O)) ? slv_mem[int'(ADR_O)] : 8'h00;
            slv_beat++;
            rty_cnt = 0;
          end
        end
      end else begin
        if (stb_run != 0) last_run = stb_run;
        stb_run = 0;
      end
    end
  end

  // Write-byte source.
  initial begin
    forever begin
      @(negedge CLK_I);
      if (took && wq.size() > 0) begin
        void'(wq.pop_front());
        fetched++;
      end
      if (wq.size() > 0 && (wv_stall == 0 || $urandom_range(0, 2) != 0)) begin
        i_wvalid = 1'b1;
        i_wdata  = wq[0];
      end else begin
        i_wvalid = 1'b0;
        i_wdata  = 8'($urandom);
      end
      #1 took = o_wready;
    end
  end

  // Read-data monitor.
  initial begin
    forever begin
      @(negedge CLK_I);
      if (o_rvalid) begin
        if (exp_rd.size() == 0) fail("extra_rvalid", 32'(o_rdata), 32'hFFFFFFFF);
        else check("rdata", 32'(o_rdata), 32'(exp_rd.pop_front()));
      end
    end
  end

  // Completion monitor.
  initial begin
    forever begin
      @(negedge CLK_I);
      if (o_done) begin
        done_count++;
        if (exp_done.size() == 0) fail("extra_done", 32'(o_error), 32'hFFFFFFFF);
        else check("done_err_busy", 32'({o_error, o_busy}), 32'({exp_done.pop_front(), 1'b0}));
      end
    end
  end

  task automatic do_xfer(input logic we, input logic [19:0] addr, input int len,
                         input int mode, input int fbeat, input bit poke);
    int n_ack, exp_fetch, dc0, f0, c0, cyc;
    logic err;
    logic [7:0] d[$];
    logic [7:0] b;
    logic [19:0] a;
    beat_t eb;
    err = 1'b0;
    n_ack = len;
    if (len == 0) begin
      err = 1'b1;
    end else if (mode == FErr || mode == FNoAck || mode == FRty4) begin
      n_ack = fbeat - 1;
      err = 1'b1;
    end
    exp_fetch = (!we || len == 0) ? 0 : (err ? fbeat : len);
    for (int i = 0; i < len; i++) begin
      b = (i < ovr.size()) ? ovr[i] : 8'($urandom);
      d.push_back(b);
      if (we) wq.push_back(b);
    end
    ovr.delete();
    for (int i = 0; i < n_ack; i++) begin
      a = addr + 20'(i);
      eb.addr = a;
      eb.we   = we;
      eb.data = we ? d[i] : 8'h00;
      exp_beats.push_back(eb);
      if (we) ref_mem[int'(a)] = d[i];
      else exp_rd.push_back(ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00);
    end
    exp_done.push_back(err);
    flt_mode = mode;
    flt_beat = fbeat;
    dc0 = done_count;
    f0  = fetched;
    c0  = cyc_rises;
    @(negedge CLK_I);
    i_req  = 1'b1;
    i_we   = we;
    i_addr = addr;
    i_len  = 8'(len);
    @(negedge CLK_I);
    i_req  = 1'b0;
    i_addr = 20'($urandom);
    i_len  = 8'($urandom);
    #2;
    if (len == 0) check("len0_done_next", 32'(done_count - dc0), 32'd1);
    else check("busy_after_req", 32'(o_busy), 32'd1);
    cyc = 0;
    while (done_count == dc0 && cyc < 500) begin
      @(negedge CLK_I);
      #2;
      cyc++;
      if (poke && cyc == 2) begin
        i_req = 1'b1;
        i_len = 8'd0;
      end else begin
        i_req = 1'b0;
      end
    end
    i_req = 1'b0;
    if (done_count == dc0) fail("done_timeout", 32'(cyc), 32'd500);
    if (we) check("fetch_count", 32'(fetched - f0), 32'(exp_fetch));
    check("cyc_rises", 32'(cyc_rises - c0), (len > 0) ? 32'd1 : 32'd0);
    wq.delete();
    flt_mode = FNone;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, 32'({CYC_O, STB_O, WE_O, LOCK_O, o_busy, o_done, o_error,
                                o_wready, o_rvalid}), 32'd0);
    check({name, "_adr"}, 32'(ADR_O), 32'd0);
    check({name, "_dat"}, 32'({DAT_O, o_rdata}), 32'd0);
    check({name, "_tag"}, 32'({TGC_O, TGA_O, TGD_O}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dc0;
    logic [19:0] a;
    int len;
    #12;
    check_all_zero("reset");
    @(negedge CLK_I);
    RST_I = 1'b0;
    repeat (2) @(negedge CLK_I);

    // Directed block write / read-back.
    ovr = '{8'hC9, 8'h47, 8'h5A};
    do_xfer(1'b1, 20'h01777, 3, FNone, 0, 1'b0);
    do_xfer(1'b0, 20'h01777, 3, FNone, 0, 1'b0);
    // Address wrap at the top of the space.
    do_xfer(1'b1, 20'hFFFFF, 2, FNone, 0, 1'b0);
    do_xfer(1'b0, 20'hFFFFF, 2, FNone, 0, 1'b0);
    // Empty request.
    do_xfer(1'b1, 20'h00123, 0, FNone, 0, 1'b0);
    // Error on beat 2 of 4, then a normal read with an ignored request while busy.
    lat_max = 1;
    do_xfer(1'b1, 20'h04000, 4, FErr, 2, 1'b0);
    do_xfer(1'b0, 20'h01111, 3, FNone, 0, 1'b1);
    do_xfer(1'b0, 20'h04000, 4, FNone, 0, 1'b0);
    // Watchdog abort.
    lat_max = 0;
    do_xfer(1'b0, 20'h02000, 2, FNoAck, 1, 1'b0);
    check("watchdog_stb_cycles", 32'(last_run), 32'd15);
    // Retry exhaustion, then retries that recover with write data kept.
    do_xfer(1'b1, 20'h03000, 3, FRty4, 2, 1'b0);
    do_xfer(1'b1, 20'h03100, 3, FRty2, 2, 1'b0);
    do_xfer(1'b0, 20'h03100, 3, FRty2, 3, 1'b0);

    // Reset mid-beat: asynchronous clear, no completion afterwards.
    flt_mode = FNoAck;
    flt_beat = 1;
    for (int i = 0; i < 3; i++) wq.push_back(8'($urandom));
    @(negedge CLK_I);
    i_req  = 1'b1;
    i_we   = 1'b1;
    i_addr = 20'h05000;
    i_len  = 8'd3;
    @(negedge CLK_I);
    i_req = 1'b0;
    repeat (4) @(negedge CLK_I);
    check("pre_reset_stb", 32'(STB_O), 32'd1);
    #3 RST_I = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge CLK_I);
    @(negedge CLK_I);
    RST_I = 1'b0;
    wq.delete();
    flt_mode = FNone;
    dc0 = done_count;
    repeat (20) @(negedge CLK_I);
    #2 check("no_done_after_reset", 32'(done_count), 32'(dc0));

    // Randomized write / read-back pairs with latency and source stalls.
    for (int t = 0; t < 30; t++) begin
      a = (t % 4 == 0) ? (20'hFFFFF - 20'($urandom_range(0, 3))) : 20'($urandom);
      len = $urandom_range(1, 6);
      lat_max = $urandom_range(0, 2);
      wv_stall = $urandom_range(0, 1);
      do_xfer(1'b1, a, len, FNone, 0, 1'b0);
      do_xfer(1'b0, a, len, FNone, 0, 1'b0);
    end

    repeat (3) @(negedge CLK_I);
    check("beats_left", 32'(exp_beats.size()), 32'd0);
    check("rdata_left", 32'(exp_rd.size()), 32'd0);
    check("done_left", 32'(exp_done.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
